bus_addr_decode: RTL

// - Request side of the CPU data bus. The read-return mux consumes the rdata_sel this block produces.
// - Decodes each CPU load/store address into data memory (per0), peripheral (per1) or unmapped.
// - Drives the byte write enables and the per1 handshake.
// - Emits rdata_sel time-aligned with the returning read data: 2'b01 dmem, 2'b10 peripheral, 2'b00 none (rdata=0).
// - Stalls the CPU via cpu_ready until the access completes.

---
 rtl/bus_addr_decode.sv | 118 +++++++++++
 1 files changed

// File: rtl/bus_addr_decode.sv
// CPU data-bus request decoder: routes loads/stores to dmem, peripheral or error.
// Optional peripheral timeout is compiled in with `define BUS_TIMEOUT_EN.
module bus_addr_decode #(
  parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
  parameter logic [31:0] DMEM_SIZE   = 32'h0000_1000,
  parameter logic [31:0] PER_BASE    = 32'h0000_2000,
  parameter logic [31:0] PER_SIZE    = 32'h0000_0100,
  parameter int          PER_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        bus_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  we_per0,
  output logic [3:0]  we_per1,
  output logic        per1_req,
  input  logic        per1_ready,
  output logic [1:0]  rdata_sel
);

  typedef enum logic [2:0] {IDLE, DMEM_ACC, DMEM_RD, PER_ACC, ERR} state_t;

  state_t     state, state_nxt;
  logic [3:0] we_q;
  logic       dmem_hit, per_hit, is_write, timeout;

  // 33-bit compares so a window ending at 2^32 cannot wrap to zero
  logic [32:0] addr33;
  assign addr33   = {1'b0, cpu_addr};
  assign dmem_hit = (addr33 >= {1'b0, DMEM_BASE}) &&
                    (addr33 <  ({1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE}));
  assign per_hit  = (addr33 >= {1'b0, PER_BASE}) &&
                    (addr33 <  ({1'b0, PER_BASE} + {1'b0, PER_SIZE}));
  assign is_write = |we_q;

`ifdef BUS_TIMEOUT_EN
  logic [4:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset)                 to_cnt <= '0;
    else if (state != PER_ACC) to_cnt <= '0;
    else if (!per1_ready)      to_cnt <= to_cnt + 5'd1;
  end

  // per1_ready takes priority over the timeout in the same cycle
  assign timeout = (state == PER_ACC) && !per1_ready &&
                   (to_cnt == 5'(PER_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= '0;
    end else if (state == IDLE && cpu_req) begin
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
      we_q      <= cpu_we;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cpu_req) state_nxt = dmem_hit ? DMEM_ACC : (per_hit ? PER_ACC : ERR);
      DMEM_ACC: state_nxt = is_write ? IDLE : DMEM_RD;
      DMEM_RD:  state_nxt = IDLE;
      PER_ACC:  if (per1_ready) state_nxt = IDLE;
                else if (timeout) state_nxt = ERR;
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    bus_err   = 1'b0;
    we_per0   = '0;
    we_per1   = '0;
    per1_req  = 1'b0;
    rdata_sel = 2'b00;
    case (state)
      DMEM_ACC: begin
        we_per0   = we_q;
        cpu_ready = is_write;
      end
      DMEM_RD: begin
        cpu_ready = 1'b1;
        rdata_sel = 2'b01;
      end
      PER_ACC: begin
        per1_req  = 1'b1;
        we_per1   = we_q;
        cpu_ready = per1_ready;
        if (per1_ready && !is_write) rdata_sel = 2'b10;
      end
      ERR: begin
        cpu_ready = 1'b1;
        bus_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
